// File: rtl/counter_step_arbiter.sv
// rtl/counter_step_arbiter.sv - round-robin sharing of a 4-bit step counter between requesters
// Each grant runs an optional counter clear, then a burst of enable cycles, then a one-cycle done.
module counter_step_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int LEN_W   = 4
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset_n,
   input  logic [NUM_REQ-1:0]       i_Req,
   input  logic [NUM_REQ*LEN_W-1:0] i_Len,
   input  logic [NUM_REQ-1:0]       i_ClearFirst,
   output logic [NUM_REQ-1:0]       o_Grant,
   output logic [NUM_REQ-1:0]       o_Done,
   output logic                     o_CounterReset,
   output logic                     o_CounterEnable,
   output logic                     o_Busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STEP,
      ST_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [IDX_W-1:0]   last;
   logic [IDX_W-1:0]   last_nxt;
   logic [LEN_W-1:0]   remaining;
   logic [LEN_W-1:0]   remaining_nxt;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [LEN_W-1:0]   win_len;

   logic [NUM_REQ-1:0] grant_nxt;
   logic [NUM_REQ-1:0] done_nxt;
   logic               counter_reset_nxt;
   logic               counter_enable_nxt;
   logic               busy_nxt;

   function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return IDX_W'(sum);
   endfunction

   // Scan starts just past the last winner, so the previous owner is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!win_found && i_Req[rr_pick(last, i)]) begin
            win_found = 1'b1;
            win_idx   = rr_pick(last, i);
         end
      end
      win_len = i_Len[win_idx*LEN_W +: LEN_W];
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      last_nxt      = last;
      remaining_nxt = remaining;
      case (state)
         ST_IDLE: begin
            if (win_found) begin
               idx_nxt       = win_idx;
               last_nxt      = win_idx;
               remaining_nxt = win_len;
               if (i_ClearFirst[win_idx]) begin
                  state_nxt = ST_CLEAR;
               end else if (win_len != '0) begin
                  state_nxt = ST_STEP;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_CLEAR: begin
            state_nxt = (remaining != '0) ? ST_STEP : ST_DONE;
         end
         ST_STEP: begin
            remaining_nxt = remaining - 1'b1;
            if (remaining <= LEN_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it.
   always_comb begin
      grant_nxt          = '0;
      done_nxt           = '0;
      counter_reset_nxt  = (state_nxt == ST_CLEAR);
      counter_enable_nxt = (state_nxt == ST_STEP);
      busy_nxt           = (state_nxt != ST_IDLE);
      if (state_nxt != ST_IDLE) begin
         grant_nxt = NUM_REQ'(1) << idx_nxt;
      end
      if (state_nxt == ST_DONE) begin
         done_nxt = NUM_REQ'(1) << idx_nxt;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Reset_n) begin
         state           <= ST_IDLE;
         idx             <= '0;
         last            <= IDX_W'(NUM_REQ - 1);
         remaining       <= '0;
         o_Grant         <= '0;
         o_Done          <= '0;
         o_CounterReset  <= 1'b1;
         o_CounterEnable <= 1'b0;
         o_Busy          <= 1'b0;
      end else begin
         state           <= state_nxt;
         idx             <= idx_nxt;
         last            <= last_nxt;
         remaining       <= remaining_nxt;
         o_Grant         <= grant_nxt;
         o_Done          <= done_nxt;
         o_CounterReset  <= counter_reset_nxt;
         o_CounterEnable <= counter_enable_nxt;
         o_Busy          <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_counter_step_arbiter.sv
// tb/tb_counter_step_arbiter.sv - bench for counter_step_arbiter
// Cycle schedule model plus a 4-bit counter fed by the arbiter's reset/enable pins.
module tb_counter_step_arbiter;

   localparam int N  = 4;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*LW-1:0] len;
   logic [N-1:0]    clr;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic            creset;
   logic            cen;
   logic            busy;
   logic [3:0]      cnt;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   counter_step_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
      .i_Clock         (clk),
      .i_Reset_n       (rst_n),
      .i_Req           (req),
      .i_Len           (len),
      .i_ClearFirst    (clr),
      .o_Grant         (grant),
      .o_Done          (done),
      .o_CounterReset  (creset),
      .o_CounterEnable (cen),
      .o_Busy          (busy)
   );

   always @(posedge clk) begin
      if (creset) cnt <= 4'd0;
      else if (cen) cnt <= cnt + 4'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: on each arbitration a list of cycle kinds is queued and then replayed.
   localparam int K_RST = 0, K_IDLE = 1, K_CLEAR = 2, K_STEP = 3, K_DONE = 4;
   int sched[$];
   int cur     = K_RST;
   int m_idx   = 0;
   int m_last  = N - 1;
   int m_len   = 0;
   int m_k;
   bit found;
   bit started = 1'b0;

   always @(posedge clk) begin
      started = 1'b1;
      if (rst_n !== 1'b1) begin
         sched.delete();
         cur    = K_RST;
         m_last = N - 1;
      end else if (sched.size() > 0) begin
         cur = sched.pop_front();
      end else begin
         cur   = K_IDLE;
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            m_k = (m_last + i) % N;
            if (!found && req[m_k]) begin
               found  = 1'b1;
               m_idx  = m_k;
            end
         end
         if (found) begin
            m_last = m_idx;
            m_len  = int'(len[m_idx*LW +: LW]);
            if (clr[m_idx]) sched.push_back(K_CLEAR);
            repeat (m_len) sched.push_back(K_STEP);
            sched.push_back(K_DONE);
            sched.push_back(K_IDLE);
            cur = sched.pop_front();
         end
      end
   end

   logic [N-1:0] eg;
   int ens = 0;

   always @(negedge clk) begin
      if (started) begin
         eg = (cur >= K_CLEAR) ? (N'(1) << m_idx) : '0;
         chk("grant", grant, eg);
         chk("done", done, (cur == K_DONE) ? eg : '0);
         chk("counter_reset", creset, (cur == K_RST || cur == K_CLEAR));
         chk("counter_enable", cen, (cur == K_STEP));
         chk("busy", busy, (cur >= K_CLEAR));
         chk("grant_onehot0", $onehot0(grant), 1);
         chk("reset_enable_exclusive", creset & cen, 0);
         if (cur == K_RST) begin
            ens = 0;
         end else begin
            if (cen) ens++;
            if (done != '0) begin
               chk("enables_per_done", ens, m_len);
               ens = 0;
            end
         end
      end
   end

   task automatic wait_done(input int budget, output int who);
      who = -1;
      for (int i = 0; i < budget && who < 0; i++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) if (done[k]) who = k;
      end
      if (who < 0) begin
         nchecks++;
         nerrors++;
         $display("FAIL done_timeout: no done within %0d cycles at %0t", budget, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int who;
   int order[$];
   int en_seen;
   int expo[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n = 1'b0;
      req   = '0;
      len   = '0;
      clr   = '0;

      // 1: single burst of 5 straight after reset release
      do_reset();
      len[0 +: LW] = 4'd5;
      req = 4'b0001;
      rst_n = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         chk("t1_grant", grant, (c <= 6) ? 1 : 0);
         chk("t1_enable", cen, (c <= 5) ? 1 : 0);
         chk("t1_done", done, (c == 6) ? 1 : 0);
         if (c == 1) chk("t1_reset_released", creset, 0);
         if (c == 6) begin
            chk("t1_count", cnt, 5);
            req = '0;
         end
      end

      // 2: all four requesting, len 2 with clear, round-robin order
      do_reset();
      len = 16'h2222;
      clr = 4'b1111;
      req = 4'b1111;
      rst_n = 1'b1;
      for (int s = 0; s < 5; s++) begin
         wait_done(20, who);
         order.push_back(who);
         chk("t2_count_at_done", cnt, 2);
         if (s == 4) req = '0;
      end
      for (int s = 0; s < 5; s++) chk("t2_order", order[s], expo[s]);

      // 3: zero-length bursts with and without clear
      do_reset();
      len = '0;
      clr = 4'b0001;
      req = 4'b0001;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t3_clear_reset", creset, 1);
      chk("t3_clear_enable", cen, 0);
      chk("t3_clear_grant", grant, 4'b0001);
      @(negedge clk);
      chk("t3_done_a", done, 4'b0001);
      chk("t3_enable_a", cen, 0);
      req = 4'b0010;
      clr = '0;
      @(negedge clk);
      chk("t3_idle_busy", busy, 0);
      @(negedge clk);
      chk("t3_done_b", done, 4'b0010);
      chk("t3_enable_b", cen, 0);
      req = 4'b0100;
      len[2*LW +: LW] = 4'd3;

      // 4: start at 3, then a 15-step burst whose inputs change mid-burst
      wait_done(20, who);
      chk("t4_first_who", who, 2);
      chk("t4_start_count", cnt, 3);
      req = 4'b1000;
      len[3*LW +: LW] = 4'd15;
      en_seen = 0;
      who = -1;
      for (int i = 0; i < 40 && who < 0; i++) begin
         @(negedge clk);
         if (cen) en_seen++;
         if (en_seen == 3) begin
            req = '0;
            len = '0;
         end
         if (done != '0) who = 1;
      end
      chk("t4_enables", en_seen, 15);
      chk("t4_done_who", done, 4'b1000);
      chk("t4_wrap", cnt, 2);

      // 5: reset in the middle of a burst, pointer returns to favour req 0
      @(negedge clk);
      len[0 +: LW] = 4'd10;
      req = 4'b0001;
      who = -1;
      for (int i = 0; i < 10 && who < 0; i++) begin
         @(negedge clk);
         if (cen) who = 0;
      end
      chk("t5_in_step", cen, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      req = 4'b0101;
      len[0 +: LW] = 4'd2;
      len[2*LW +: LW] = 4'd1;
      @(negedge clk);
      chk("t5_abort_grant", grant, 0);
      chk("t5_abort_enable", cen, 0);
      chk("t5_abort_reset", creset, 1);
      chk("t5_abort_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_after_grant", grant, 4'b0001);
      wait_done(20, who);
      chk("t5_first", who, 0);
      req = 4'b0100;
      wait_done(20, who);
      chk("t5_second", who, 2);
      req = '0;

      // 6: random traffic with occasional reset, checked by the model
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (done[k]) begin
               req[k] = 1'b0;
            end else if (!req[k] && $urandom_range(0, 3) == 0) begin
               req[k] = 1'b1;
               len[k*LW +: LW] = ($urandom_range(0, 7) == 0) ? 4'd15 : LW'($urandom_range(0, 5));
               clr[k] = 1'($urandom_range(0, 1));
            end
         end
         rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      end
      rst_n = 1'b1;
      req = '0;
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
